snn_inference_ctrl: RTL and testbench

Sequencer between the AXI slave interface and the SNN core. On each new-image notification it streams the 256 stored pixels to the core over a valid/ready handshake, fires the core, waits for its completion, and latches the inferred digit with the ready flag that the AXI side reads back. It owns the start/busy/result life-cycle of one inference at a time.

---
 rtl/snn_ctrl_pkg.sv | 22 ++
 rtl/snn_pixel_streamer.sv | 77 +++++++
 rtl/snn_inference_ctrl.sv | 96 +++++++++
 tb/tb_snn_inference_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared types and sizing constants for the SNN inference sequencer.
package snn_ctrl_pkg;

   localparam int unsigned IMAGE_SIZE      = 256;
   localparam int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
   localparam int unsigned PIXEL_BITS      = 8;
   localparam int unsigned DIGIT_BITS      = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STREAM,
      ST_FIRE,
      ST_WAIT_CORE,
      ST_RESULT
   } ctrl_state_t;

   typedef struct packed {
      logic [IMAGE_SIZE_BITS-1:0] addr;
      logic [PIXEL_BITS-1:0]      data;
   } pixel_beat_t;

endpackage

// File: rtl/snn_pixel_streamer.sv
// Walks the stored image over a valid/ready link and flags the final index.
// ZERO_SKIP_EN: zero pixels are stepped over without a handshake.
module snn_pixel_streamer
   import snn_ctrl_pkg::*;
(
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] image_i,
   input  logic                                  pixel_ready_i,
   output logic                                  pixel_valid_o,
   output logic [IMAGE_SIZE_BITS-1:0]            pixel_addr_o,
   output logic [PIXEL_BITS-1:0]                 pixel_data_o,
   output logic                                  last_done_c_o
);

   localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);

   logic        active_q, active_d;
   logic        valid_q, valid_d;
   pixel_beat_t beat_q, beat_d;
   logic        adv;
   logic        last;
   logic        keep;
   logic [PIXEL_BITS-1:0] pix;

   // An index retires on handshake, or at once when it is not being offered.
   always_comb begin
      active_d = active_q;
      valid_d  = valid_q;
      beat_d   = beat_q;
      pix      = '0;
      keep     = 1'b0;
      adv      = active_q & (pixel_ready_i | ~valid_q);
      last     = adv & (beat_q.addr == LAST_IDX);

      if (start_i) begin
         active_d    = 1'b1;
         beat_d.addr = '0;
      end else if (last) begin
         active_d    = 1'b0;
         valid_d     = 1'b0;
         beat_d.data = '0;
      end else if (adv) begin
         beat_d.addr = beat_q.addr + IMAGE_SIZE_BITS'(1);
      end

      if (start_i || (adv && !last)) begin
         pix = image_i[beat_d.addr];
`ifdef ZERO_SKIP_EN
         keep = (pix != '0);
`else
         keep = 1'b1;
`endif
         valid_d     = keep;
         beat_d.data = keep ? pix : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         valid_q  <= 1'b0;
         beat_q   <= '0;
      end else begin
         active_q <= active_d;
         valid_q  <= valid_d;
         beat_q   <= beat_d;
      end
   end

   assign pixel_valid_o = valid_q;
   assign pixel_addr_o  = beat_q.addr;
   assign pixel_data_o  = beat_q.data;
   assign last_done_c_o = last;

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference life-cycle sequencer: stream image, fire core, latch digit.
// ZERO_SKIP_EN (in snn_pixel_streamer): skip zero-valued pixels.
module snn_inference_ctrl
   import snn_ctrl_pkg::*;
(
   input  logic                                  ACLK,
   input  logic                                  ARESETN,
   input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
   input  logic                                  NEW_IMAGE,
   output logic                                  BUSY,
   output logic                                  PIXEL_VALID,
   input  logic                                  PIXEL_READY,
   output logic [IMAGE_SIZE_BITS-1:0]            PIXEL_ADDR,
   output logic [PIXEL_BITS-1:0]                 PIXEL_DATA,
   output logic                                  CORE_START,
   input  logic                                  CORE_DONE,
   input  logic [DIGIT_BITS-1:0]                 CORE_DIGIT,
   output logic                                  COPROCESSOR_RDY,
   output logic [DIGIT_BITS-1:0]                 INFERED_DIGIT
);

   ctrl_state_t           state_q, state_d;
   logic                  new_image_q;
   logic                  busy_q, busy_d;
   logic                  core_start_q, core_start_d;
   logic                  rdy_q, rdy_d;
   logic [DIGIT_BITS-1:0] digit_q, digit_d;
   logic                  start_req;
   logic                  accept;
   logic                  last_done;

   assign start_req = NEW_IMAGE & ~new_image_q;
   assign accept    = start_req & ((state_q == ST_IDLE) | (state_q == ST_RESULT));

   snn_pixel_streamer u_streamer (
      .clk_i         (ACLK),
      .rst_ni        (ARESETN),
      .start_i       (accept),
      .image_i       (IMAGE),
      .pixel_ready_i (PIXEL_READY),
      .pixel_valid_o (PIXEL_VALID),
      .pixel_addr_o  (PIXEL_ADDR),
      .pixel_data_o  (PIXEL_DATA),
      .last_done_c_o (last_done)
   );

   // State and registered outputs.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= ST_IDLE;
         new_image_q  <= 1'b0;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
         rdy_q        <= 1'b0;
         digit_q      <= '0;
      end else begin
         state_q      <= state_d;
         new_image_q  <= NEW_IMAGE;
         busy_q       <= busy_d;
         core_start_q <= core_start_d;
         rdy_q        <= rdy_d;
         digit_q      <= digit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_RESULT: if (start_req) state_d = ST_STREAM;
         ST_STREAM:          if (last_done) state_d = ST_FIRE;
         ST_FIRE:            state_d = ST_WAIT_CORE;
         ST_WAIT_CORE:       if (CORE_DONE) state_d = ST_RESULT;
         default:            state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_comb begin
      busy_d       = (state_d == ST_STREAM) | (state_d == ST_FIRE) | (state_d == ST_WAIT_CORE);
      core_start_d = (state_d == ST_FIRE);
      rdy_d        = rdy_q;
      digit_d      = digit_q;
      if (accept) begin
         rdy_d = 1'b0;
      end else if ((state_q == ST_WAIT_CORE) && CORE_DONE) begin
         rdy_d   = 1'b1;
         digit_d = CORE_DIGIT;
      end
   end

   assign BUSY            = busy_q;
   assign CORE_START      = core_start_q;
   assign COPROCESSOR_RDY = rdy_q;
   assign INFERED_DIGIT   = digit_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl; expectations follow ZERO_SKIP_EN.
module tb_snn_inference_ctrl;
   import snn_ctrl_pkg::*;

   logic                                  ACLK = 1'b0;
   logic                                  ARESETN;
   logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE;
   logic                                  NEW_IMAGE;
   logic                                  BUSY;
   logic                                  PIXEL_VALID;
   logic                                  PIXEL_READY;
   logic [IMAGE_SIZE_BITS-1:0]            PIXEL_ADDR;
   logic [PIXEL_BITS-1:0]                 PIXEL_DATA;
   logic                                  CORE_START;
   logic                                  CORE_DONE;
   logic [DIGIT_BITS-1:0]                 CORE_DIGIT;
   logic                                  COPROCESSOR_RDY;
   logic [DIGIT_BITS-1:0]                 INFERED_DIGIT;

   int checks = 0;
   int errors = 0;

   int xa[$];
   int xd[$];
   int start_cnt, busy_err, stall_err, zero_err;
   logic prev_stall;
   logic [IMAGE_SIZE_BITS-1:0] prev_addr;
   logic [PIXEL_BITS-1:0]      prev_data;

   int  cyc;
   bit  found;

   always #5 ACLK = ~ACLK;

   snn_inference_ctrl dut (
      .ACLK            (ACLK),
      .ARESETN         (ARESETN),
      .IMAGE           (IMAGE),
      .NEW_IMAGE       (NEW_IMAGE),
      .BUSY            (BUSY),
      .PIXEL_VALID     (PIXEL_VALID),
      .PIXEL_READY     (PIXEL_READY),
      .PIXEL_ADDR      (PIXEL_ADDR),
      .PIXEL_DATA      (PIXEL_DATA),
      .CORE_START      (CORE_START),
      .CORE_DONE       (CORE_DONE),
      .CORE_DIGIT      (CORE_DIGIT),
      .COPROCESSOR_RDY (COPROCESSOR_RDY),
      .INFERED_DIGIT   (INFERED_DIGIT)
   );

   // Transfer monitor, sampled mid-cycle after inputs settle.
   always @(negedge ACLK) begin
      #3;
      if (!ARESETN) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!PIXEL_VALID || PIXEL_ADDR != prev_addr || PIXEL_DATA != prev_data))
            stall_err++;
         if (PIXEL_VALID && !BUSY) busy_err++;
         if (!PIXEL_VALID && PIXEL_DATA != '0) zero_err++;
         if (CORE_START) start_cnt++;
         if (PIXEL_VALID && PIXEL_READY) begin
            xa.push_back(int'(PIXEL_ADDR));
            xd.push_back(int'(PIXEL_DATA));
         end
         prev_stall = PIXEL_VALID & ~PIXEL_READY;
         prev_addr  = PIXEL_ADDR;
         prev_data  = PIXEL_DATA;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit keep_pix(input logic [PIXEL_BITS-1:0] p);
`ifdef ZERO_SKIP_EN
      return p != '0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic tick();
      @(negedge ACLK);
      #1;
   endtask

   task automatic clear_mon();
      xa.delete();
      xd.delete();
      start_cnt = 0;
      busy_err  = 0;
      stall_err = 0;
      zero_err  = 0;
   endtask

   // Runs until CORE_START is seen; optionally random READY and ignored events.
   task automatic wait_start(input int budget, input bit rnd, output int n, output bit seen);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (CORE_START) seen = 1'b1;
         if (rnd) begin
            PIXEL_READY = 1'($urandom_range(0, 1));
            if (n == 40) NEW_IMAGE = 1'b0;
            if (n == 42) NEW_IMAGE = 1'b1;
            if (n == 60) begin CORE_DONE = 1'b1; CORE_DIGIT = 8'd9; end
            if (n == 61) begin CORE_DONE = 1'b0; CORE_DIGIT = 8'd0; end
         end
      end
   endtask

   task automatic check_stream();
      int j;
      int expn;
      expn = 0;
      for (int i = 0; i < IMAGE_SIZE; i++) if (keep_pix(IMAGE[i])) expn++;
      check("xfer_count", 32'(xa.size()), 32'(expn));
      j = 0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
         if (keep_pix(IMAGE[i]) && j < xa.size()) begin
            check("xfer_addr", 32'(xa[j]), 32'(i));
            check("xfer_data", 32'(xd[j]), 32'(IMAGE[i]));
            j++;
         end
      end
      check("busy_while_valid", 32'(busy_err), 32'd0);
      check("stall_stable", 32'(stall_err), 32'd0);
      check("data_zero_idle", 32'(zero_err), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},  32'(BUSY), 32'd0);
      check({tag, "_valid"}, 32'(PIXEL_VALID), 32'd0);
      check({tag, "_addr"},  32'(PIXEL_ADDR), 32'd0);
      check({tag, "_data"},  32'(PIXEL_DATA), 32'd0);
      check({tag, "_start"}, 32'(CORE_START), 32'd0);
      check({tag, "_rdy"},   32'(COPROCESSOR_RDY), 32'd0);
      check({tag, "_digit"}, 32'(INFERED_DIGIT), 32'd0);
   endtask

   initial begin
      ARESETN     = 1'b0;
      NEW_IMAGE   = 1'b0;
      PIXEL_READY = 1'b0;
      CORE_DONE   = 1'b0;
      CORE_DIGIT  = '0;
      prev_stall  = 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
         if ((i / 16) >= 3 && (i / 16) <= 12 && (i % 16) >= 5 && (i % 16) <= 10)
            IMAGE[i] = 8'(i * 3 + 17);
         else
            IMAGE[i] = 8'd0;
      end
      clear_mon();

      // Reset state
      repeat (3) tick();
      check_reset_vals("reset");
      ARESETN = 1'b1;
      tick();

      // Full stream, READY tied high
      clear_mon();
      PIXEL_READY = 1'b1;
      NEW_IMAGE   = 1'b1;
      tick();
      check("s1_busy", 32'(BUSY), 32'd1);
      check("s1_valid0", 32'(PIXEL_VALID), 32'(keep_pix(IMAGE[0])));
      check("s1_addr0", 32'(PIXEL_ADDR), 32'd0);
      check("s1_data0", 32'(PIXEL_DATA), keep_pix(IMAGE[0]) ? 32'(IMAGE[0]) : 32'd0);
      wait_start(600, 1'b0, cyc, found);
      check("s1_start_seen", 32'(found), 32'd1);
      check("s1_start_latency", 32'(cyc), 32'd256);
      check("s1_busy_fire", 32'(BUSY), 32'd1);
      tick();
      check("s1_start_pulse", 32'(CORE_START), 32'd0);
      check("s1_busy_wait", 32'(BUSY), 32'd1);
      check("s1_start_cnt", 32'(start_cnt), 32'd1);
      check_stream();

      // Core completes 3000 ns after start
      repeat (299) tick();
      check("s1_rdy_wait", 32'(COPROCESSOR_RDY), 32'd0);
      CORE_DONE  = 1'b1;
      CORE_DIGIT = 8'd5;
      tick();
      CORE_DONE  = 1'b0;
      CORE_DIGIT = 8'hAA;
      check("s1_rdy", 32'(COPROCESSOR_RDY), 32'd1);
      check("s1_digit", 32'(INFERED_DIGIT), 32'd5);
      check("s1_busy_result", 32'(BUSY), 32'd0);
      repeat (5) tick();
      CORE_DONE  = 1'b1;
      CORE_DIGIT = 8'd77;
      tick();
      CORE_DONE  = 1'b0;
      tick();
      check("s1_rdy_hold", 32'(COPROCESSOR_RDY), 32'd1);
      check("s1_digit_hold", 32'(INFERED_DIGIT), 32'd5);
      NEW_IMAGE = 1'b0;
      tick();
      check("s1_rdy_fall", 32'(COPROCESSOR_RDY), 32'd1);

      // Random READY with ignored restart and CORE_DONE during stream
      clear_mon();
      PIXEL_READY = 1'b0;
      NEW_IMAGE   = 1'b1;
      tick();
      check("s2_rdy_clr", 32'(COPROCESSOR_RDY), 32'd0);
      check("s2_busy", 32'(BUSY), 32'd1);
      check("s2_digit_keep", 32'(INFERED_DIGIT), 32'd5);
      wait_start(3000, 1'b1, cyc, found);
      PIXEL_READY = 1'b1;
      check("s2_start_seen", 32'(found), 32'd1);
      tick();
      check("s2_start_cnt", 32'(start_cnt), 32'd1);
      check("s2_rdy_ignored", 32'(COPROCESSOR_RDY), 32'd0);
      check("s2_busy_wait", 32'(BUSY), 32'd1);
      check_stream();
      CORE_DONE  = 1'b1;
      CORE_DIGIT = 8'd3;
      tick();
      CORE_DONE  = 1'b0;
      check("s2_rdy", 32'(COPROCESSOR_RDY), 32'd1);
      check("s2_digit", 32'(INFERED_DIGIT), 32'd3);

      // Reset in the middle of a stream
      NEW_IMAGE = 1'b0;
      tick();
      NEW_IMAGE = 1'b1;
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 300) begin
         tick();
         cyc++;
         if (PIXEL_ADDR == IMAGE_SIZE_BITS'(100)) found = 1'b1;
      end
      check("s3_reach_100", 32'(found), 32'd1);
      ARESETN   = 1'b0;
      NEW_IMAGE = 1'b0;
      #1;
      check_reset_vals("s3_reset");
      tick();
      ARESETN = 1'b1;
      tick();
      check("s3_idle", 32'(BUSY), 32'd0);
      clear_mon();
      NEW_IMAGE = 1'b1;
      tick();
      check("s3_busy", 32'(BUSY), 32'd1);
      check("s3_addr0", 32'(PIXEL_ADDR), 32'd0);
      wait_start(600, 1'b0, cyc, found);
      check("s3_start_seen", 32'(found), 32'd1);
      check("s3_start_latency", 32'(cyc), 32'd256);
      tick();
      check_stream();
      CORE_DONE  = 1'b1;
      CORE_DIGIT = 8'h42;
      tick();
      CORE_DONE  = 1'b0;
      check("s3_digit", 32'(INFERED_DIGIT), 32'h42);

      // All-zero image
      IMAGE     = '0;
      NEW_IMAGE = 1'b0;
      tick();
      clear_mon();
      NEW_IMAGE = 1'b1;
      tick();
      check("s4_busy", 32'(BUSY), 32'd1);
      wait_start(600, 1'b0, cyc, found);
      check("s4_start_seen", 32'(found), 32'd1);
      check("s4_start_latency", 32'(cyc), 32'd256);
      tick();
      check("s4_start_cnt", 32'(start_cnt), 32'd1);
      check_stream();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
